fifo_out_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one 36-bit output FIFO write port among NREQ 32-bit streaming sources. Each grant moves a bounded burst from one source. Every FIFO word carries a 4-bit tag in the parity lane: DI[35] is end-of-packet, DI[34:32] is the source id. The block sits in the write clock domain, directly in front of the output FIFO's DI/WREN.

---
 rtl/fifo_out_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_fifo_out_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_out_arbiter.sv
// Round-robin write-side arbiter sharing one 36-bit FIFO write port among NREQ 32-bit sources.
// Define FIFO_ARB_WATCHDOG_EN to add the stall watchdog and the sticky STALL_ERR output.
module fifo_out_arbiter #(
   parameter int NREQ      = 4,
   parameter int BURST     = 16,
   parameter int STALL_MAX = 64
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [NREQ-1:0]      REQ_VALID,
   input  logic [32*NREQ-1:0]   REQ_DATA,
   input  logic [NREQ-1:0]      REQ_LAST,
   output logic [NREQ-1:0]      REQ_READY,
   input  logic                 AFULL,
   output logic [35:0]          DI,
   output logic                 WREN,
   output logic [NREQ-1:0]      GRANT,
   output logic                 BUSY
`ifdef FIFO_ARB_WATCHDOG_EN
   ,
   output logic                 STALL_ERR
`endif
);

   generate
      if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
         $error("fifo_out_arbiter: NREQ must be in 1..8");
      end
      if (BURST < 1 || BURST > 256) begin : g_bad_burst
         $error("fifo_out_arbiter: BURST must be in 1..256");
      end
      if (STALL_MAX < 1) begin : g_bad_stall
         $error("fifo_out_arbiter: STALL_MAX must be at least 1");
      end
   endgenerate

   typedef enum logic {
      IDLE,
      XFER
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        ptr;
   logic [2:0]        ptr_nxt;
   logic [2:0]        gid;
   logic [2:0]        gid_nxt;
   logic [2:0]        gid_inc;
   logic [2:0]        winner;
   logic [8:0]        count;
   logic [8:0]        count_nxt;
   logic [NREQ-1:0]   grant_nxt;
   logic [2*NREQ-1:0] dbl_valid;
   logic [2*NREQ-1:0] shifted_valid;
   logic [NREQ-1:0]   rot_valid;
   logic              found;
   logic              valid_g;
   logic              last_g;
   logic [31:0]       data_g;
   logic              xfer;
   logic              stall_hit;

   // Rotate the valid vector so that bit 0 is the source at the round-robin pointer.
   assign dbl_valid     = {REQ_VALID, REQ_VALID};
   assign shifted_valid = dbl_valid >> ptr;
   assign rot_valid     = shifted_valid[NREQ-1:0];

   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && rot_valid[k]) begin
            found  = 1'b1;
            winner = 3'((int'(ptr) + k) % NREQ);
         end
      end
   end

   // GRANT is one-hot, so masking with it selects the granted source's lane.
   assign valid_g = |(REQ_VALID & GRANT);
   assign last_g  = |(REQ_LAST & GRANT);

   always_comb begin
      data_g = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (GRANT[i]) begin
            data_g = data_g | REQ_DATA[32*i +: 32];
         end
      end
   end

   assign gid_inc   = (int'(gid) == NREQ - 1) ? 3'd0 : gid + 3'd1;
   assign xfer      = (state == XFER) && valid_g;
   assign BUSY      = (state == XFER);
   assign REQ_READY = BUSY ? GRANT : '0;

`ifdef FIFO_ARB_WATCHDOG_EN
   logic [15:0] stall_cnt;

   assign stall_hit = (state == XFER) && !valid_g && (stall_cnt == 16'(STALL_MAX - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stall_cnt <= '0;
         STALL_ERR <= 1'b0;
      end else begin
         if (state != XFER || valid_g || stall_hit) begin
            stall_cnt <= '0;
         end else begin
            stall_cnt <= stall_cnt + 16'd1;
         end
         if (stall_hit) begin
            STALL_ERR <= 1'b1;
         end
      end
   end
`else
   assign stall_hit = 1'b0;
`endif

   // Next-state logic: grant on an idle cycle, release on LAST, burst limit or stall.
   always_comb begin
      state_nxt = state;
      grant_nxt = GRANT;
      gid_nxt   = gid;
      ptr_nxt   = ptr;
      count_nxt = count;
      case (state)
         IDLE: begin
            if (!AFULL && found) begin
               state_nxt = XFER;
               grant_nxt = NREQ'(1) << winner;
               gid_nxt   = winner;
               count_nxt = '0;
            end
         end
         XFER: begin
            if (xfer) begin
               count_nxt = count + 9'd1;
            end
            if ((xfer && (last_g || count == 9'(BURST - 1))) || stall_hit) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               ptr_nxt   = gid_inc;
               count_nxt = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         ptr   <= '0;
         gid   <= '0;
         count <= '0;
         GRANT <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         gid   <= gid_nxt;
         count <= count_nxt;
         GRANT <= grant_nxt;
      end
   end

   // DI keeps its last written word on cycles without a transfer.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         DI   <= '0;
         WREN <= 1'b0;
      end else begin
         WREN <= xfer;
         if (xfer) begin
            DI <= {last_g, gid, data_g};
         end
      end
   end

endmodule

// File: tb/tb_fifo_out_arbiter.sv
// Directed self-checking bench for fifo_out_arbiter (NREQ=4, BURST=4, default build).
module tb_fifo_out_arbiter;

   localparam int NREQ  = 4;
   localparam int BURST = 4;

   logic                 CLK;
   logic                 RST_N;
   logic [NREQ-1:0]      REQ_VALID;
   logic [32*NREQ-1:0]   REQ_DATA;
   logic [NREQ-1:0]      REQ_LAST;
   logic [NREQ-1:0]      REQ_READY;
   logic                 AFULL;
   logic [35:0]          DI;
   logic                 WREN;
   logic [NREQ-1:0]      GRANT;
   logic                 BUSY;

   int total_chk;
   int bad_chk;
   int src_total [NREQ];
   int src_plen  [NREQ];
   int src_idx   [NREQ];
   logic [35:0] wlog[$];
   logic [35:0] exp_q[$];

   fifo_out_arbiter #(
      .NREQ(NREQ),
      .BURST(BURST),
      .STALL_MAX(8)
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .REQ_VALID(REQ_VALID),
      .REQ_DATA(REQ_DATA),
      .REQ_LAST(REQ_LAST),
      .REQ_READY(REQ_READY),
      .AFULL(AFULL),
      .DI(DI),
      .WREN(WREN),
      .GRANT(GRANT),
      .BUSY(BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("[TB] FAIL timeout reached");
      $fatal(1, "[TB] timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total_chk++;
      assert (obs === expv) else begin
         bad_chk++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [35:0] exp_word(input logic [3:0] tag, input int src, input int n);
      return {tag, 8'(src), 24'(n)};
   endfunction

   task automatic drive_sources();
      for (int i = 0; i < NREQ; i++) begin
         REQ_VALID[i]         = (src_idx[i] < src_total[i]);
         REQ_LAST[i]          = (src_idx[i] < src_total[i]) &&
                                ((src_idx[i] % src_plen[i]) == src_plen[i] - 1);
         REQ_DATA[32*i +: 32] = {8'(i), 24'(src_idx[i])};
      end
   endtask

   task automatic step();
      logic [NREQ-1:0] fired;
      fired = REQ_VALID & REQ_READY;
      @(posedge CLK);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (fired[i]) src_idx[i]++;
      end
      drive_sources();
      if (WREN) wlog.push_back(DI);
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_sources();
      for (int i = 0; i < NREQ; i++) begin
         src_total[i] = 0;
         src_plen[i]  = 1;
         src_idx[i]   = 0;
      end
      drive_sources();
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      AFULL = 1'b0;
      clear_sources();
      step_n(2);
      RST_N = 1'b1;
      step();
      wlog.delete();
   endtask

   initial begin
      logic seen;
      total_chk = 0;
      bad_chk   = 0;
      RST_N     = 1'b1;
      AFULL     = 1'b0;
      clear_sources();
      #2 RST_N = 1'b0;
      #1;
      check("reset_di", 64'(DI), 64'd0);
      check("reset_wren", 64'(WREN), 64'd0);
      check("reset_grant", 64'(GRANT), 64'd0);
      check("reset_busy", 64'(BUSY), 64'd0);
      check("reset_ready", 64'(REQ_READY), 64'd0);
      step_n(2);
      RST_N = 1'b1;
      step();
      wlog.delete();

      // Scenario 1: single 3-word packet from source 0
      src_total[0] = 3;
      src_plen[0]  = 3;
      drive_sources();
      step();
      check("s1_grant", 64'(GRANT), 64'h1);
      check("s1_busy", 64'(BUSY), 64'd1);
      check("s1_wren_idle", 64'(WREN), 64'd0);
      check("s1_ready", 64'(REQ_READY), 64'h1);
      for (int j = 0; j < 3; j++) begin
         step();
         check("s1_wren", 64'(WREN), 64'd1);
         check("s1_di", 64'(DI), 64'(exp_word((j == 2) ? 4'h8 : 4'h0, 0, j)));
      end
      check("s1_release_grant", 64'(GRANT), 64'd0);
      check("s1_release_busy", 64'(BUSY), 64'd0);
      step();
      check("s1_wren_after", 64'(WREN), 64'd0);

      // Scenario 2: all sources continuously valid with 2-word packets
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         src_total[i] = 4;
         src_plen[i]  = 2;
      end
      drive_sources();
      for (int g = 0; g < 6; g++) begin
         int s;
         int n;
         s = g % 4;
         n = (g / 4) * 2;
         step();
         check("s2_grant", 64'(GRANT), 64'(4'b0001 << s));
         check("s2_bubble", 64'(WREN), 64'd0);
         step();
         check("s2_w0", 64'(DI), 64'(exp_word(4'(s), s, n)));
         step();
         check("s2_w1", 64'(DI), 64'(exp_word(4'(8 + s), s, n + 1)));
         check("s2_release", 64'(GRANT), 64'd0);
      end

      // Scenario 3: burst cut of a 10-word packet interleaved with a 1-word packet
      do_reset();
      src_total[1] = 10;
      src_plen[1]  = 10;
      src_total[2] = 1;
      src_plen[2]  = 1;
      drive_sources();
      step_n(20);
      exp_q.delete();
      for (int n = 0; n < 4; n++) exp_q.push_back(exp_word(4'h1, 1, n));
      exp_q.push_back(exp_word(4'hA, 2, 0));
      for (int n = 4; n < 9; n++) exp_q.push_back(exp_word(4'h1, 1, n));
      exp_q.push_back(exp_word(4'h9, 1, 9));
      check("s3_count", 64'(wlog.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) begin
         if (k < wlog.size()) check("s3_word", 64'(wlog[k]), 64'(exp_q[k]));
      end

      // Scenario 4: AFULL blocks new grants but not a running burst
      do_reset();
      AFULL        = 1'b1;
      src_total[0] = 3;
      src_plen[0]  = 3;
      src_total[2] = 3;
      src_plen[2]  = 3;
      drive_sources();
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         seen = seen | (|GRANT) | WREN;
      end
      check("s4_afull_hold", 64'(seen), 64'd0);
      AFULL = 1'b0;
      step();
      check("s4_grant0", 64'(GRANT), 64'h1);
      AFULL = 1'b1;
      step_n(3);
      check("s4_burst_done", 64'(wlog.size()), 64'd3);
      check("s4_last_word", 64'(DI), 64'(exp_word(4'h8, 0, 2)));
      check("s4_released", 64'(GRANT), 64'd0);
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         seen = seen | (|GRANT) | WREN;
      end
      check("s4_afull_hold2", 64'(seen), 64'd0);
      AFULL = 1'b0;
      step();
      check("s4_grant2", 64'(GRANT), 64'h4);

      // Scenario 5: reset in the middle of a burst
      do_reset();
      src_total[1] = 1;
      src_plen[1]  = 1;
      drive_sources();
      step_n(3);
      src_total[0] = 5;
      src_plen[0]  = 5;
      drive_sources();
      step();
      check("s5_grant0", 64'(GRANT), 64'h1);
      step_n(2);
      RST_N = 1'b0;
      wlog.delete();
      #1;
      check("s5_rst_di", 64'(DI), 64'd0);
      check("s5_rst_wren", 64'(WREN), 64'd0);
      check("s5_rst_grant", 64'(GRANT), 64'd0);
      check("s5_rst_busy", 64'(BUSY), 64'd0);
      check("s5_rst_ready", 64'(REQ_READY), 64'd0);
      step_n(3);
      check("s5_no_writes", 64'(wlog.size()), 64'd0);
      RST_N        = 1'b1;
      src_total[2] = 1;
      src_plen[2]  = 1;
      drive_sources();
      step();
      check("s5_restart_grant", 64'(GRANT), 64'h1);

      $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
      $finish;
   end

endmodule
